hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the pipelined datapath. Replaces separate
//  hazard-detect and forwarding units with one scoreboard tracking in-flight writers across
//  FWD_STAGES post-ID stages and a configurable load latency. Sits beside the ID stage, drives
//  PC/IF_ID write enables, the ID/EX bubble and IF/ID flush. Issues registered forward selects
//  to the EX operand muxes.
// PARAMETERS
//  REG_NUMBER    5  register index width
//  FWD_STAGES    3  post-ID stages tracked (S1=EX .. S{FWD_STAGES}); legal 2..7
//  LOAD_LATENCY  1  extra cycles after EX before load data is forwardable; FWD_STAGES>=1+LOAD_LATENCY
//  SEL_W  $clog2(FWD_STAGES+1)  forward select width (localparam)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-high
//  id_valid      in   1           ID holds a real instruction
//  id_rs1        in   REG_NUMBER  ID source 1 index
//  id_rs2        in   REG_NUMBER  ID source 2 index
//  id_use_rs1    in   1           instruction reads rs1
//  id_use_rs2    in   1           instruction reads rs2
//  id_rd         in   REG_NUMBER  ID destination index
//  id_reg_write  in   1           instruction writes rd
//  id_mem_read   in   1           instruction is a load
//  branch_taken  in   1           ID resolved a taken branch/jump
//  mem_busy      in   1           data memory stall; freezes whole pipeline
//  pc_write      out  1           PC update enable
//  if_id_write   out  1           IF/ID register enable
//  id_ex_bubble  out  1           zero ID/EX control fields this edge
//  flush         out  1           clear IF/ID this edge
//  fwd_a         out  SEL_W       EX operand A select: 0=regfile, k=result of instr k stages ahead
//  fwd_b         out  SEL_W       EX operand B select, same encoding
// BEHAVIOUR
//  - Scoreboard: FWD_STAGES entries {valid, rd, reg_write, is_load}; entry j = instr in Sj.
//  - Reset: all entries invalid, fwd_a=fwd_b=0; comb outputs evaluate on empty board
//    (pc_write=if_id_write=~mem_busy, id_ex_bubble=0, flush=0).
//  - Match: entry j matches rsX iff valid && reg_write && rd==rsX && rsX!=0 && id_use_rsX.
//    Index 0 never hazards or forwards. Youngest match (smallest j) wins.
//  - Load hazard: hz = id_valid && a matching entry j has is_load && j<1+LOAD_LATENCY.
//  - Priority: mem_busy > hz > branch_taken.
//  - mem_busy=1: board, fwd_a/b hold; pc_write=if_id_write=0; id_ex_bubble=0; flush=0.
//  - hz=1 (no mem_busy): pc_write=if_id_write=0, id_ex_bubble=1, flush=0; board shifts,
//    S1 <= invalid; fwd_a/b <= 0.
//  - Else: pc_write=if_id_write=1, id_ex_bubble=0, flush=branch_taken&&id_valid; board shifts,
//    S1 <= {id_valid,id_rd,id_reg_write,id_mem_read}; fwd_a/b <= matched j, else 0.
//  - Latency: fwd_a/b registered, valid in the cycle the instr occupies EX (1 cycle after issue).
//  - Shift: S(j+1) <= Sj; oldest entry retires. Writer in S{FWD_STAGES} at issue is visible
//    via regfile (no forwarding needed beyond the tracked depth).
//  - Reset mid-operation clears board immediately; no partial issue survives.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[31:0], bubble_count[31:0],
//   flush_count[31:0]. Increment on mem_busy, hz, flush cycles respectively. Saturate at
//   32'hFFFF_FFFF. Reset to 0.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  1 Back-to-back ALU: I1 rd=3, I2 rs1=3 -> no stall; fwd_a=1 in I2's EX cycle, fwd_b=0.
//  2 Load-use, LOAD_LATENCY=1: LW rd=5, next rs2=5 -> 1 cycle pc_write=0, id_ex_bubble=1;
//    then issue with fwd_b=2.
//  3 LOAD_LATENCY=2, FWD_STAGES=4: load rd=7 then rs1=7 -> 2 bubble cycles, then fwd_a=3.
//  4 rd=0 writer then rs1=0 reader -> no stall, fwd_a=0.
//  5 Load-use hazard with branch_taken=1 -> flush=0 during stall; flush=1 on issue cycle.
//  6 mem_busy for 3 cycles mid-sequence -> board and fwd_a/b frozen, no bubbles;
//    rst=1 asynchronously -> fwd_a=fwd_b=0, board empty.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard beside ID: tracks in-flight writers, stalls load-use, issues EX forward selects.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/bubble/flush counters.
module hazard_scoreboard #(
  parameter int REG_NUMBER   = 5,
  parameter int FWD_STAGES   = 3,
  parameter int LOAD_LATENCY = 1,
  localparam int SEL_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_NUMBER-1:0] i_id_rs1,
  input  logic [REG_NUMBER-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_NUMBER-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_busy,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_bubble,
  output logic                  o_flush,
  output logic [SEL_W-1:0]      o_fwd_a,
  output logic [SEL_W-1:0]      o_fwd_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_bubble_count,
  output logic [31:0]           o_flush_count
`endif
);

  logic [FWD_STAGES-1:0] r_valid;
  logic [FWD_STAGES-1:0] r_regWrite;
  logic [FWD_STAGES-1:0] r_isLoad;
  logic [REG_NUMBER-1:0] r_rd [FWD_STAGES];
  logic [SEL_W-1:0]      r_fwdA;
  logic [SEL_W-1:0]      r_fwdB;

  logic [SEL_W-1:0]      w_selA;
  logic [SEL_W-1:0]      w_selB;
  logic                  w_loadHzA;
  logic                  w_loadHzB;
  logic                  w_hz;

  // Descending scan so the youngest (lowest stage) match overwrites older ones.
  always_comb begin
    w_selA    = '0;
    w_selB    = '0;
    w_loadHzA = 1'b0;
    w_loadHzB = 1'b0;
    for (int j = FWD_STAGES - 1; j >= 0; j--) begin
      if (r_valid[j] && r_regWrite[j] && (r_rd[j] == i_id_rs1) &&
          (i_id_rs1 != '0) && i_id_use_rs1) begin
        w_selA = SEL_W'(j + 1);
        if (r_isLoad[j] && (j < LOAD_LATENCY)) w_loadHzA = 1'b1;
      end
      if (r_valid[j] && r_regWrite[j] && (r_rd[j] == i_id_rs2) &&
          (i_id_rs2 != '0) && i_id_use_rs2) begin
        w_selB = SEL_W'(j + 1);
        if (r_isLoad[j] && (j < LOAD_LATENCY)) w_loadHzB = 1'b1;
      end
    end
  end

  assign w_hz           = i_id_valid && (w_loadHzA || w_loadHzB);
  assign o_pc_write     = !i_mem_busy && !w_hz;
  assign o_if_id_write  = !i_mem_busy && !w_hz;
  assign o_id_ex_bubble = !i_mem_busy && w_hz;
  assign o_flush        = !i_mem_busy && !w_hz && i_branch_taken && i_id_valid;
  assign o_fwd_a        = r_fwdA;
  assign o_fwd_b        = r_fwdB;

  // A stall inserts an empty slot at S1 while older writers keep draining.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid    <= '0;
      r_regWrite <= '0;
      r_isLoad   <= '0;
      for (int j = 0; j < FWD_STAGES; j++) r_rd[j] <= '0;
      r_fwdA     <= '0;
      r_fwdB     <= '0;
    end else if (!i_mem_busy) begin
      r_valid    <= {r_valid[FWD_STAGES-2:0],    i_id_valid && !w_hz};
      r_regWrite <= {r_regWrite[FWD_STAGES-2:0], i_id_reg_write && !w_hz};
      r_isLoad   <= {r_isLoad[FWD_STAGES-2:0],   i_id_mem_read && !w_hz};
      r_rd[0]    <= w_hz ? '0 : i_id_rd;
      for (int j = 1; j < FWD_STAGES; j++) r_rd[j] <= r_rd[j-1];
      r_fwdA     <= w_hz ? '0 : w_selA;
      r_fwdB     <= w_hz ? '0 : w_selB;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
      o_bubble_count <= '0;
      o_flush_count  <= '0;
    end else begin
      if (i_mem_busy && (o_stall_cycles != 32'hFFFF_FFFF))
        o_stall_cycles <= o_stall_cycles + 32'd1;
      if (o_id_ex_bubble && (o_bubble_count != 32'hFFFF_FFFF))
        o_bubble_count <= o_bubble_count + 32'd1;
      if (o_flush && (o_flush_count != 32'hFFFF_FFFF))
        o_flush_count <= o_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance (3 stages, load latency 1)
// plus a 4-stage / load-latency-2 instance sharing the same ID-stage stimulus.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       idValid;
  logic [4:0] idRs1;
  logic [4:0] idRs2;
  logic       idUseRs1;
  logic       idUseRs2;
  logic [4:0] idRd;
  logic       idRegWrite;
  logic       idMemRead;
  logic       branchTaken;
  logic       memBusy;

  logic       pcWriteA, ifIdWriteA, bubbleA, flushA;
  logic [1:0] fwdAA, fwdBA;
  logic       pcWriteB, ifIdWriteB, bubbleB, flushB;
  logic [2:0] fwdAB, fwdBB;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallA, bubCntA, flushCntA;
  logic [31:0] stallB, bubCntB, flushCntB;
`endif

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.REG_NUMBER(5), .FWD_STAGES(3), .LOAD_LATENCY(1)) dutA (
    .i_clk(clk), .i_rst(rst), .i_id_valid(idValid), .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_use_rs1(idUseRs1), .i_id_use_rs2(idUseRs2), .i_id_rd(idRd),
    .i_id_reg_write(idRegWrite), .i_id_mem_read(idMemRead), .i_branch_taken(branchTaken),
    .i_mem_busy(memBusy), .o_pc_write(pcWriteA), .o_if_id_write(ifIdWriteA),
    .o_id_ex_bubble(bubbleA), .o_flush(flushA), .o_fwd_a(fwdAA), .o_fwd_b(fwdBA)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(stallA), .o_bubble_count(bubCntA), .o_flush_count(flushCntA)
`endif
  );

  hazard_scoreboard #(.REG_NUMBER(5), .FWD_STAGES(4), .LOAD_LATENCY(2)) dutB (
    .i_clk(clk), .i_rst(rst), .i_id_valid(idValid), .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_use_rs1(idUseRs1), .i_id_use_rs2(idUseRs2), .i_id_rd(idRd),
    .i_id_reg_write(idRegWrite), .i_id_mem_read(idMemRead), .i_branch_taken(branchTaken),
    .i_mem_busy(memBusy), .o_pc_write(pcWriteB), .o_if_id_write(ifIdWriteB),
    .o_id_ex_bubble(bubbleB), .o_flush(flushB), .o_fwd_a(fwdAB), .o_fwd_b(fwdBB)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(stallB), .o_bubble_count(bubCntB), .o_flush_count(flushCntB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one ID-stage vector, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic br, input logic busy);
    idValid     = v;
    idRs1       = rs1;
    idRs2       = rs2;
    idUseRs1    = u1;
    idUseRs2    = u2;
    idRd        = rd;
    idRegWrite  = rw;
    idMemRead   = mr;
    branchTaken = br;
    memBusy     = busy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    assert (actual === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    // Reset: empty board, registered selects cleared
    checkOutput("rst_fwd_a", 32'(fwdAA), 0);
    checkOutput("rst_fwd_b", 32'(fwdBA), 0);
    checkOutput("rst_fwd_a_B", 32'(fwdAB), 0);
    checkOutput("rst_pc_write", 32'(pcWriteA), 1);
    checkOutput("rst_bubble", 32'(bubbleA), 0);
    checkOutput("rst_flush", 32'(flushA), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_busy_pc_write", 32'(pcWriteA), 0);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("rst_stall_cnt", stallA, 0);
    checkOutput("rst_bubble_cnt", bubCntA, 0);
    checkOutput("rst_flush_cnt", flushCntA, 0);
`endif
    tick();
    rst = 1'b0;
    drain(1);

    // Back-to-back ALU forwarding from S1
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 3, 4, 1, 1, 6, 1, 0, 0, 0);
    checkOutput("alu_pc_write", 32'(pcWriteA), 1);
    checkOutput("alu_bubble", 32'(bubbleA), 0);
    tick();
    checkOutput("alu_fwd_a", 32'(fwdAA), 1);
    checkOutput("alu_fwd_b", 32'(fwdBA), 0);
    drain(4);

    // x0 never forwards
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 0, 7, 1, 0, 0, 0);
    checkOutput("x0_pc_write", 32'(pcWriteA), 1);
    tick();
    checkOutput("x0_fwd_a", 32'(fwdAA), 0);
    drain(4);

    // Load-use: one bubble, then forward from S2
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 1, 5, 1, 1, 8, 1, 0, 0, 0);
    checkOutput("lu_pc_write", 32'(pcWriteA), 0);
    checkOutput("lu_if_id_write", 32'(ifIdWriteA), 0);
    checkOutput("lu_bubble", 32'(bubbleA), 1);
    checkOutput("lu_flush", 32'(flushA), 0);
    tick();
    checkOutput("lu_stall_fwd_b", 32'(fwdBA), 0);
    checkOutput("lu_release_pc_write", 32'(pcWriteA), 1);
    checkOutput("lu_release_bubble", 32'(bubbleA), 0);
    tick();
    checkOutput("lu_fwd_b", 32'(fwdBA), 2);
    checkOutput("lu_fwd_a", 32'(fwdAA), 0);
    drain(4);

    // Load-use with taken branch: flush deferred to issue cycle
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 9, 0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("br_stall_flush", 32'(flushA), 0);
    checkOutput("br_stall_bubble", 32'(bubbleA), 1);
    tick();
    checkOutput("br_issue_flush", 32'(flushA), 1);
    checkOutput("br_issue_pc_write", 32'(pcWriteA), 1);
    tick();
    checkOutput("br_fwd_a", 32'(fwdAA), 2);
    drain(5);

    // Load latency 2 on the 4-stage instance: two bubbles, then forward from S3
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 7, 0, 1, 0, 2, 1, 0, 0, 0);
    checkOutput("ll2_bubble1", 32'(bubbleB), 1);
    tick();
    checkOutput("ll2_bubble2", 32'(bubbleB), 1);
    checkOutput("ll2_pc_write_stall", 32'(pcWriteB), 0);
    tick();
    checkOutput("ll2_bubble3", 32'(bubbleB), 0);
    checkOutput("ll2_pc_write", 32'(pcWriteB), 1);
    tick();
    checkOutput("ll2_fwd_a", 32'(fwdAB), 3);
    drain(5);

    // mem_busy freezes board and selects; priority over branch flush
    applyStimulus(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 10, 0, 1, 0, 11, 1, 0, 0, 0);
    tick();
    checkOutput("busy_pre_fwd_a", 32'(fwdAA), 1);
    applyStimulus(1, 11, 10, 1, 1, 12, 1, 0, 1, 1);
    checkOutput("busy_pc_write", 32'(pcWriteA), 0);
    checkOutput("busy_if_id_write", 32'(ifIdWriteA), 0);
    checkOutput("busy_bubble", 32'(bubbleA), 0);
    checkOutput("busy_flush", 32'(flushA), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("busy_hold_fwd_a", 32'(fwdAA), 1);
      checkOutput("busy_hold_fwd_b", 32'(fwdBA), 0);
    end
    applyStimulus(1, 11, 10, 1, 1, 12, 1, 0, 0, 0);
    checkOutput("busy_release_pc_write", 32'(pcWriteA), 1);
    tick();
    checkOutput("busy_after_fwd_a", 32'(fwdAA), 1);
    checkOutput("busy_after_fwd_b", 32'(fwdBA), 2);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_fwd_a", 32'(fwdAA), 0);
    checkOutput("arst_fwd_b", 32'(fwdBA), 0);
    rst = 1'b0;
    applyStimulus(1, 12, 11, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("arst_pc_write", 32'(pcWriteA), 1);
    tick();
    checkOutput("arst_empty_fwd_a", 32'(fwdAA), 0);
    checkOutput("arst_empty_fwd_b", 32'(fwdBA), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
